// File: rtl/dp_sequencer.sv
// dp_sequencer: multi-cycle sequencer for ARM data-processing instructions.
// Accepts a decoded instruction and its operands, evaluates the condition
// field against NZCV, drives the external ALU from registers for one EXEC
// cycle, updates NZCV when S is set and hands the result to the register file.
// Optional feature: define DP_COND_EN to enable condition-code evaluation;
// when undefined every data-processing instruction executes as AL.
module dp_sequencer (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic [31:0] INSTR,
  input  logic [31:0] RN_DATA,
  input  logic [31:0] OP2_DATA,
  input  logic        SHIFT_COUT,
  output logic [31:0] ALU_LEFT,
  output logic [31:0] ALU_RIGHT,
  output logic [3:0]  ALU_FN,
  output logic        ALU_CIN,
  input  logic [31:0] ALU_RESULT,
  input  logic        ALU_COUT,
  input  logic        ALU_V,
  output logic        WB_VALID,
  input  logic        WB_READY,
  output logic [3:0]  WB_RD,
  output logic [31:0] WB_DATA,
  output logic [3:0]  FLAGS
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t      r_state;
  logic [3:0]  r_flags;      // {N, Z, C, V}
  logic        r_s;          // latched S bit
  logic [3:0]  r_rd;         // latched destination register
  logic        r_scout;      // latched shifter carry-out
  logic [31:0] r_alu_left;
  logic [31:0] r_alu_right;
  logic [3:0]  r_alu_fn;
  logic        r_alu_cin;
  logic        r_wb_valid;
  logic [3:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic        w_is_dp;
  logic        w_cond;
  logic        w_go;
  logic        w_cin_op;
  logic        w_arith;
  logic        w_compare;
  logic [3:0]  w_flags_next;
  logic        w_unused;

`ifdef DP_COND_EN
  // Condition check against NZCV; flags is {N, Z, C, V}.
  function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c && !z;
      4'b1001: cond_pass = !c || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign w_cond = cond_pass(INSTR[31:28], r_flags);
`else
  assign w_cond = 1'b1;
`endif

  // Only the fields the sequencer needs are decoded; the rest belong to the
  // decoder/shifter upstream.
  assign w_unused  = &{1'b0, INSTR[31:28], INSTR[19:16], INSTR[11:0]};

  assign w_is_dp   = (INSTR[27:26] == 2'b00);
  assign w_go      = w_is_dp && w_cond;
  assign w_cin_op  = (INSTR[24:21] == 4'b0101) || (INSTR[24:21] == 4'b0110) ||
                     (INSTR[24:21] == 4'b0111);

  // Classification of the opcode currently executing.
  assign w_arith   = ((r_alu_fn >= 4'b0010) && (r_alu_fn <= 4'b0111)) ||
                     (r_alu_fn == 4'b1010) || (r_alu_fn == 4'b1011);
  assign w_compare = (r_alu_fn[3:2] == 2'b10);

  assign w_flags_next = {ALU_RESULT[31],
                         (ALU_RESULT == 32'd0),
                         w_arith ? ALU_COUT : r_scout,
                         w_arith ? ALU_V    : r_flags[0]};

  assign INSTR_READY = (r_state == S_IDLE);
  assign ALU_LEFT    = r_alu_left;
  assign ALU_RIGHT   = r_alu_right;
  assign ALU_FN      = r_alu_fn;
  assign ALU_CIN     = r_alu_cin;
  assign WB_VALID    = r_wb_valid;
  assign WB_RD       = r_wb_rd;
  assign WB_DATA     = r_wb_data;
  assign FLAGS       = r_flags;

  // Sequencer FSM: accept, one-cycle EXEC, then hold writeback until taken.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_flags     <= 4'b0000;
      r_s         <= 1'b0;
      r_rd        <= 4'd0;
      r_scout     <= 1'b0;
      r_alu_left  <= 32'd0;
      r_alu_right <= 32'd0;
      r_alu_fn    <= 4'd0;
      r_alu_cin   <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 4'd0;
      r_wb_data   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // NOPs and failed conditions are consumed here without any effect.
          if (INSTR_VALID && w_go) begin
            r_alu_left  <= RN_DATA;
            r_alu_right <= OP2_DATA;
            r_alu_fn    <= INSTR[24:21];
            r_alu_cin   <= w_cin_op && r_flags[1];
            r_s         <= INSTR[20];
            r_rd        <= INSTR[15:12];
            r_scout     <= SHIFT_COUT;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_s) begin
            r_flags <= w_flags_next;
          end
          if (w_compare) begin
            r_state <= S_IDLE;
          end else begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= ALU_RESULT;
            r_state    <= S_WB;
          end
        end
        S_WB: begin
          if (WB_READY) begin
            r_wb_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer with a behavioural ARM ALU stand-in.
// Expectations follow DP_COND_EN: condition-dependent steps branch on it.
module tb_dp_sequencer;

  logic        CLK;
  logic        RESET_N;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [31:0] INSTR;
  logic [31:0] RN_DATA;
  logic [31:0] OP2_DATA;
  logic        SHIFT_COUT;
  logic [31:0] ALU_LEFT;
  logic [31:0] ALU_RIGHT;
  logic [3:0]  ALU_FN;
  logic        ALU_CIN;
  logic [31:0] ALU_RESULT;
  logic        ALU_COUT;
  logic        ALU_V;
  logic        WB_VALID;
  logic        WB_READY;
  logic [3:0]  WB_RD;
  logic [31:0] WB_DATA;
  logic [3:0]  FLAGS;

  int checks   = 0;
  int failures = 0;

  dp_sequencer dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY),
    .INSTR      (INSTR),
    .RN_DATA    (RN_DATA),
    .OP2_DATA   (OP2_DATA),
    .SHIFT_COUT (SHIFT_COUT),
    .ALU_LEFT   (ALU_LEFT),
    .ALU_RIGHT  (ALU_RIGHT),
    .ALU_FN     (ALU_FN),
    .ALU_CIN    (ALU_CIN),
    .ALU_RESULT (ALU_RESULT),
    .ALU_COUT   (ALU_COUT),
    .ALU_V      (ALU_V),
    .WB_VALID   (WB_VALID),
    .WB_READY   (WB_READY),
    .WB_RD      (WB_RD),
    .WB_DATA    (WB_DATA),
    .FLAGS      (FLAGS)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural ARM ALU: arithmetic ops are a + b + ci on 33 bits.
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_ci;
  logic        alu_arith;
  logic [32:0] alu_sum;

  always_comb begin
    alu_a     = ALU_LEFT;
    alu_b     = ALU_RIGHT;
    alu_ci    = 1'b0;
    alu_arith = 1'b1;
    alu_sum   = 33'd0;
    ALU_RESULT = 32'd0;
    ALU_COUT   = 1'b0;
    ALU_V      = 1'b0;
    case (ALU_FN)
      4'h2, 4'hA: begin alu_b = ~ALU_RIGHT; alu_ci = 1'b1;    end
      4'h3:       begin alu_a = ALU_RIGHT; alu_b = ~ALU_LEFT; alu_ci = 1'b1; end
      4'h4, 4'hB: begin alu_ci = 1'b0;                        end
      4'h5:       begin alu_ci = ALU_CIN;                     end
      4'h6:       begin alu_b = ~ALU_RIGHT; alu_ci = ALU_CIN; end
      4'h7:       begin alu_a = ALU_RIGHT; alu_b = ~ALU_LEFT; alu_ci = ALU_CIN; end
      default:    alu_arith = 1'b0;
    endcase
    if (alu_arith) begin
      alu_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_ci};
      ALU_RESULT = alu_sum[31:0];
      ALU_COUT   = alu_sum[32];
      ALU_V      = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
    end else begin
      case (ALU_FN)
        4'h0, 4'h8: ALU_RESULT = ALU_LEFT & ALU_RIGHT;
        4'h1, 4'h9: ALU_RESULT = ALU_LEFT ^ ALU_RIGHT;
        4'hC:       ALU_RESULT = ALU_LEFT | ALU_RIGHT;
        4'hD:       ALU_RESULT = ALU_RIGHT;
        4'hE:       ALU_RESULT = ALU_LEFT & ~ALU_RIGHT;
        default:    ALU_RESULT = ~ALU_RIGHT;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Present one instruction for exactly one edge (edge 0 of the transaction).
  task automatic drive(input logic [31:0] ins, input logic [31:0] rn,
                       input logic [31:0] op2, input logic sc);
    chk("ready_before_accept", {31'd0, INSTR_READY}, 32'd1);
    INSTR       = ins;
    RN_DATA     = rn;
    OP2_DATA    = op2;
    SHIFT_COUT  = sc;
    INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
  endtask

  initial begin
    RESET_N     = 1'b0;
    INSTR_VALID = 1'b0;
    INSTR       = 32'd0;
    RN_DATA     = 32'd0;
    OP2_DATA    = 32'd0;
    SHIFT_COUT  = 1'b0;
    WB_READY    = 1'b1;

    // Reset state
    #2;
    chk("rst_ready",    {31'd0, INSTR_READY}, 32'd1);
    chk("rst_flags",    {28'd0, FLAGS},       32'd0);
    chk("rst_wb_valid", {31'd0, WB_VALID},    32'd0);
    chk("rst_wb_rd",    {28'd0, WB_RD},       32'd0);
    chk("rst_wb_data",  WB_DATA,              32'd0);
    chk("rst_alu_left", ALU_LEFT,             32'd0);
    chk("rst_alu_fn",   {28'd0, ALU_FN},      32'd0);
    chk("rst_alu_cin",  {31'd0, ALU_CIN},     32'd0);
    tick();
    tick();
    RESET_N = 1'b1;

    // ADDS R1,R2,R3 with signed overflow
    drive(32'hE0921003, 32'h7FFFFFFF, 32'h1, 1'b0);
    chk("adds_exec_ready", {31'd0, INSTR_READY}, 32'd0);
    chk("adds_alu_left",   ALU_LEFT,             32'h7FFFFFFF);
    chk("adds_alu_right",  ALU_RIGHT,            32'h1);
    chk("adds_alu_fn",     {28'd0, ALU_FN},      32'h4);
    chk("adds_alu_cin",    {31'd0, ALU_CIN},     32'd0);
    tick();
    chk("adds_wb_valid",   {31'd0, WB_VALID},    32'd1);
    chk("adds_wb_rd",      {28'd0, WB_RD},       32'd1);
    chk("adds_wb_data",    WB_DATA,              32'h80000000);
    chk("adds_flags",      {28'd0, FLAGS},       32'h9);
    chk("adds_wb_ready",   {31'd0, INSTR_READY}, 32'd0);
    tick();
    chk("adds_done_valid", {31'd0, WB_VALID},    32'd0);

    // CMP R2,R3 equal operands: no writeback, back in IDLE after 2 cycles
    drive(32'hE1520003, 32'd5, 32'd5, 1'b0);
    chk("cmp_alu_fn",      {28'd0, ALU_FN},      32'hA);
    tick();
    chk("cmp_wb_valid",    {31'd0, WB_VALID},    32'd0);
    chk("cmp_flags",       {28'd0, FLAGS},       32'h6);
    chk("cmp_ready",       {31'd0, INSTR_READY}, 32'd1);

    // ADDNE after CMP set Z
    drive(32'h10921003, 32'd1, 32'd2, 1'b0);
`ifdef DP_COND_EN
    chk("addne_ready",     {31'd0, INSTR_READY}, 32'd1);
    chk("addne_wb_valid",  {31'd0, WB_VALID},    32'd0);
    chk("addne_flags",     {28'd0, FLAGS},       32'h6);
`else
    chk("addne_ready",     {31'd0, INSTR_READY}, 32'd0);
    tick();
    chk("addne_wb_data",   WB_DATA,              32'd3);
    chk("addne_flags",     {28'd0, FLAGS},       32'h0);
    tick();
`endif

    // ADDEQ executes in either build
    drive(32'h00921003, 32'd1, 32'd2, 1'b0);
    tick();
    chk("addeq_wb_valid",  {31'd0, WB_VALID},    32'd1);
    chk("addeq_wb_data",   WB_DATA,              32'd3);
    chk("addeq_flags",     {28'd0, FLAGS},       32'h0);
    tick();

    // Set C with CMP, then ADC (S=0) uses carry-in and leaves flags alone
    drive(32'hE1520003, 32'd5, 32'd5, 1'b0);
    tick();
    chk("cmp2_flags",      {28'd0, FLAGS},       32'h6);
    drive(32'hE0A21003, 32'd1, 32'd2, 1'b0);
    chk("adc_alu_cin",     {31'd0, ALU_CIN},     32'd1);
    chk("adc_alu_fn",      {28'd0, ALU_FN},      32'h5);
    tick();
    chk("adc_wb_data",     WB_DATA,              32'd4);
    chk("adc_flags",       {28'd0, FLAGS},       32'h6);
    tick();

    // Set V via overflow, then ANDS: C from shifter, V retained
    drive(32'hE0921003, 32'h7FFFFFFF, 32'h1, 1'b0);
    tick();
    chk("adds2_flags",     {28'd0, FLAGS},       32'h9);
    tick();
    drive(32'hE0121003, 32'h000000F0, 32'h0000000F, 1'b1);
    chk("ands_alu_cin",    {31'd0, ALU_CIN},     32'd0);
    tick();
    chk("ands_wb_valid",   {31'd0, WB_VALID},    32'd1);
    chk("ands_wb_data",    WB_DATA,              32'd0);
    chk("ands_flags",      {28'd0, FLAGS},       32'h7);
    tick();

    // Non data-processing word is a one-cycle NOP
    drive(32'hE4000000, 32'd9, 32'd9, 1'b0);
    chk("nop_ready",       {31'd0, INSTR_READY}, 32'd1);
    chk("nop_wb_valid",    {31'd0, WB_VALID},    32'd0);
    chk("nop_flags",       {28'd0, FLAGS},       32'h7);

    // Condition 1111
    drive(32'hF0921003, 32'd1, 32'd2, 1'b0);
`ifdef DP_COND_EN
    chk("nv_ready",        {31'd0, INSTR_READY}, 32'd1);
    chk("nv_flags",        {28'd0, FLAGS},       32'h7);
`else
    tick();
    chk("nv_wb_data",      WB_DATA,              32'd3);
    chk("nv_flags",        {28'd0, FLAGS},       32'h0);
    tick();
`endif

    // Backpressure: WB held for 3 extra cycles
    WB_READY = 1'b0;
    drive(32'hE0821003, 32'd10, 32'd20, 1'b0);
    tick();
    chk("bp_wb_valid0",    {31'd0, WB_VALID},    32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_wb_valid",   {31'd0, WB_VALID},    32'd1);
      chk("bp_wb_rd",      {28'd0, WB_RD},       32'd1);
      chk("bp_wb_data",    WB_DATA,              32'h1E);
      chk("bp_ready",      {31'd0, INSTR_READY}, 32'd0);
    end
    WB_READY = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, WB_VALID},   32'd0);
    chk("bp_release_ready", {31'd0, INSTR_READY}, 32'd1);

    // Asynchronous reset during WB
    drive(32'hE1520003, 32'd5, 32'd5, 1'b0);
    tick();
    chk("pre_rst_flags",   {28'd0, FLAGS},       32'h6);
    WB_READY = 1'b0;
    drive(32'hE0821003, 32'd1, 32'd2, 1'b0);
    tick();
    chk("pre_rst_wb_valid", {31'd0, WB_VALID},   32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_wb_valid",   {31'd0, WB_VALID},    32'd0);
    chk("arst_flags",      {28'd0, FLAGS},       32'd0);
    chk("arst_wb_data",    WB_DATA,              32'd0);
    chk("arst_ready",      {31'd0, INSTR_READY}, 32'd1);
    tick();
    RESET_N  = 1'b1;
    WB_READY = 1'b1;
    tick();
    chk("post_rst_wb_valid", {31'd0, WB_VALID},  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
